// File: rtl/miniled_pkg.sv
// Shared mini-LED backlight constants and types.
// Used by the zone calculator, upload control and driver interface.
package miniled_pkg;

  localparam int ZONES        = 360;
  localparam int AW           = 10;
  localparam int DW           = 16;
  localparam int CFG_WAIT_DEF = 2500;
  localparam int PERIOD_DEF   = 420000;
  localparam int FLAG_LEN_DEF = 29;

  typedef enum logic [1:0] {
    ST_CFG,
    ST_IDLE,
    ST_FLAG,
    ST_XFER
  } upl_state_e;

  // Counter width for a 0..n-1 range, at least one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zone_upload_ctrl_period_timer.sv
// Enable-gated wrap counter with a terminal-count tick.
// Used for both the config wait and the refresh period.
module period_timer
  import miniled_pkg::*;
#(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = cnt_w(N);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick_o = (cnt_q == W'(N - 1));

  // Next count: clear wins, then wrap at N-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/zone_upload_ctrl.sv
// Periodic upload of zone values to the mini-LED driver RAM.
// Config wait, refresh ticks, flag phase, then a streamed copy.
module zone_upload_ctrl
  import miniled_pkg::*;
#(
  parameter int ZONES    = miniled_pkg::ZONES,
  parameter int AW       = miniled_pkg::AW,
  parameter int DW       = miniled_pkg::DW,
  parameter int CFG_WAIT = CFG_WAIT_DEF,
  parameter int PERIOD   = PERIOD_DEF,
  parameter int FLAG_LEN = FLAG_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_done,
  output logic          buf_rd_en,
  output logic [AW-1:0] buf_rd_addr,
  input  logic [DW-1:0] buf_rd_data,
  output logic          sdbpflag,
  output logic          wten,
  output logic [AW-1:0] wtaddr,
  output logic [DW-1:0] wtdina,
  output logic          busy,
  output logic          cfg_done,
  output logic [7:0]    drop_cnt,
  output logic          overrun
);

  localparam int FW = cnt_w(FLAG_LEN);

  upl_state_e    state_q, state_d;
  logic [FW-1:0] flag_cnt_q;
  logic [AW-1:0] rd_addr_q;
  logic          wten_q;
  logic [AW-1:0] wtaddr_q;
  logic [DW-1:0] wtdat_q;
  logic          cfg_done_q;
  logic          per_run_q;
  logic          pending_q, pending_d;
  logic [7:0]    drop_q;
  logic          overrun_q;

  logic in_cfg, in_flag, in_xfer;
  logic cfg_tick, per_tick, tick;
  logic flag_last, xfer_last, accept;

  assign in_cfg  = (state_q == ST_CFG);
  assign in_flag = (state_q == ST_FLAG);
  assign in_xfer = (state_q == ST_XFER);

  period_timer #(.N(CFG_WAIT)) u_cfg_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .en_i   (in_cfg),
    .tick_o (cfg_tick)
  );

  // Runs one cycle behind cfg_done so the first tick is PERIOD later.
  period_timer #(.N(PERIOD)) u_per_tmr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (in_cfg & cfg_tick),
    .en_i   (per_run_q),
    .tick_o (per_tick)
  );

  assign tick      = per_tick & per_run_q;
  assign flag_last = (flag_cnt_q == FW'(FLAG_LEN - 1));
  assign xfer_last = (rd_addr_q == AW'(ZONES - 1));
  assign accept    = (state_q == ST_IDLE) & tick & pending_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CFG;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CFG:  if (cfg_tick)  state_d = ST_IDLE;
      ST_IDLE: if (accept)    state_d = ST_FLAG;
      ST_FLAG: if (flag_last) state_d = ST_XFER;
      ST_XFER: if (xfer_last) state_d = ST_IDLE;
      default: state_d = ST_CFG;
    endcase
  end

  // State-decoded outputs; write data bypasses the hold register.
  always_comb begin
    sdbpflag    = in_flag;
    buf_rd_en   = in_xfer;
    buf_rd_addr = rd_addr_q;
    busy        = in_flag | in_xfer | wten_q;
    wten        = wten_q;
    wtaddr      = wtaddr_q;
    wtdina      = wten_q ? buf_rd_data : wtdat_q;
    cfg_done    = cfg_done_q;
    drop_cnt    = drop_q;
    overrun     = overrun_q;
  end

  // A new frame re-arms pending even on the accepting tick.
  always_comb begin
    pending_d = pending_q;
    if (!in_cfg) begin
      if (frame_done)  pending_d = 1'b1;
      else if (accept) pending_d = 1'b0;
    end
  end

  // Counters, read pipeline and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_cnt_q <= '0;
      rd_addr_q  <= '0;
      wten_q     <= 1'b0;
      wtaddr_q   <= '0;
      wtdat_q    <= '0;
      cfg_done_q <= 1'b0;
      per_run_q  <= 1'b0;
      pending_q  <= 1'b0;
      drop_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      flag_cnt_q <= in_flag ? flag_cnt_q + FW'(1) : '0;
      if (in_xfer && !xfer_last) rd_addr_q <= rd_addr_q + AW'(1);
      else                       rd_addr_q <= '0;
      wten_q <= in_xfer;
      if (in_xfer) wtaddr_q <= rd_addr_q;
      if (wten_q)  wtdat_q  <= buf_rd_data;
      if (in_cfg && cfg_tick) cfg_done_q <= 1'b1;
      per_run_q <= cfg_done_q;
      pending_q <= pending_d;
      if (frame_done && pending_q && !in_cfg && !in_xfer &&
          drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      if (tick && (in_flag || in_xfer)) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zone_upload_ctrl.sv
// Directed bench for zone_upload_ctrl.
// Small geometry: 8 zones, short config wait and period.
module tb_zone_upload_ctrl;

  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_done = 1'b0;
  logic frame_done2 = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  logic          rd_en1, sdbp1, wten1, busy1, cfg1, ovr1;
  logic [AW-1:0] rd_addr1, wa1;
  logic [DW-1:0] rd_data1 = '0;
  logic [DW-1:0] wd1;
  logic [7:0]    drop1;

  logic          rd_en2, sdbp2, wten2, busy2, cfg2, ovr2;
  logic [AW-1:0] rd_addr2, wa2;
  logic [DW-1:0] rd_data2 = '0;
  logic [DW-1:0] wd2;
  logic [7:0]    drop2;

  always #5 clk = ~clk;

  zone_upload_ctrl #(
    .ZONES(8), .AW(AW), .DW(DW),
    .CFG_WAIT(10), .PERIOD(50), .FLAG_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_done(frame_done),
    .buf_rd_en(rd_en1), .buf_rd_addr(rd_addr1),
    .buf_rd_data(rd_data1), .sdbpflag(sdbp1),
    .wten(wten1), .wtaddr(wa1), .wtdina(wd1),
    .busy(busy1), .cfg_done(cfg1),
    .drop_cnt(drop1), .overrun(ovr1)
  );

  zone_upload_ctrl #(
    .ZONES(8), .AW(AW), .DW(DW),
    .CFG_WAIT(10), .PERIOD(10), .FLAG_LEN(4)
  ) dut_ovr (
    .clk(clk), .rst(rst), .frame_done(frame_done2),
    .buf_rd_en(rd_en2), .buf_rd_addr(rd_addr2),
    .buf_rd_data(rd_data2), .sdbpflag(sdbp2),
    .wten(wten2), .wtaddr(wa2), .wtdina(wd2),
    .busy(busy2), .cfg_done(cfg2),
    .drop_cnt(drop2), .overrun(ovr2)
  );

  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= 16'h100 + 16'(rd_addr1);
    if (rd_en2) rd_data2 <= 16'h100 + 16'(rd_addr2);
  end

  typedef struct {
    int          c;
    logic        fd;
    logic        sdbp;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        wten;
    logic [9:0]  wa;
    logic [15:0] wd;
    logic        busy;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(int c, logic fd, logic sd, logic re,
                              int ra, logic we, int wa, int wd,
                              logic bz);
    vec_t v;
    v.c = c; v.fd = fd; v.sdbp = sd; v.rd_en = re;
    v.rd_addr = 10'(ra); v.wten = we; v.wa = 10'(wa);
    v.wd = 16'(wd); v.busy = bz;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_until(int n);
    while (cyc < n) adv();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_done = 1'b0;
    frame_done2 = 1'b0;
    adv();
    adv();
    rst = 1'b0;
    cyc = 0;
  endtask

  int n_sd2, n_we2, exp_wa2;

  initial begin
    tbl[0]  = mk(20, 1, 0, 0, 0, 0, 0, 16'h000, 0);
    tbl[1]  = mk(21, 0, 0, 0, 0, 0, 0, 16'h000, 0);
    tbl[2]  = mk(60, 0, 0, 0, 0, 0, 0, 16'h000, 0);
    tbl[3]  = mk(61, 0, 1, 0, 0, 0, 0, 16'h000, 1);
    tbl[4]  = mk(62, 0, 1, 0, 0, 0, 0, 16'h000, 1);
    tbl[5]  = mk(63, 0, 1, 0, 0, 0, 0, 16'h000, 1);
    tbl[6]  = mk(64, 0, 1, 0, 0, 0, 0, 16'h000, 1);
    tbl[7]  = mk(65, 0, 0, 1, 0, 0, 0, 16'h000, 1);
    tbl[8]  = mk(66, 0, 0, 1, 1, 1, 0, 16'h100, 1);
    tbl[9]  = mk(67, 1, 0, 1, 2, 1, 1, 16'h101, 1);
    tbl[10] = mk(68, 0, 0, 1, 3, 1, 2, 16'h102, 1);
    tbl[11] = mk(69, 1, 0, 1, 4, 1, 3, 16'h103, 1);
    tbl[12] = mk(70, 0, 0, 1, 5, 1, 4, 16'h104, 1);
    tbl[13] = mk(71, 0, 0, 1, 6, 1, 5, 16'h105, 1);
    tbl[14] = mk(72, 0, 0, 1, 7, 1, 6, 16'h106, 1);
    tbl[15] = mk(73, 0, 0, 0, 0, 1, 7, 16'h107, 1);
    tbl[16] = mk(74, 0, 0, 0, 0, 0, 7, 16'h107, 0);
    tbl[17] = mk(75, 0, 0, 0, 0, 0, 7, 16'h107, 0);
    tbl[18] = mk(76, 0, 0, 0, 0, 0, 7, 16'h107, 0);

    // Run 1: idle DUT config timing; PERIOD=10 copy overruns.
    do_reset();
    chk("rst_outs", {sdbp1, wten1, busy1, cfg1, rd_en1, ovr1}, 0);
    chk("rst_bus", {wa1, wd1, drop1}, 0);
    n_sd2 = 0;
    n_we2 = 0;
    exp_wa2 = 0;
    while (cyc < 70) begin
      adv();
      if (cyc == 9)  chk("cfg_early", cfg1, 0);
      if (cyc == 10) chk("cfg_rise", cfg1, 1);
      if (cyc == 12) frame_done2 = 1'b1;
      if (cyc == 13) frame_done2 = 1'b0;
      if (cyc == 20) chk("ovr_before", ovr2, 0);
      if (cyc == 21) chk("ovr_flag", sdbp2, 1);
      if (cyc == 31) chk("ovr_set", ovr2, 1);
      if (cyc == 61) chk("idle_tick", {sdbp1, busy1}, 0);
      if (sdbp2) n_sd2++;
      if (wten2) begin
        chk("ovr_wa", wa2, exp_wa2);
        chk("ovr_wd", wd2, 16'h100 + exp_wa2);
        exp_wa2++;
      end
      if (wten2) n_we2++;
    end
    chk("ovr_nflag", n_sd2, 4);
    chk("ovr_nwr", n_we2, 8);
    chk("ovr_sticky", ovr2, 1);

    // Run 2: normal upload, mid-transfer frames, then reset.
    do_reset();
    foreach (tbl[i]) begin
      wait_until(tbl[i].c);
      chk($sformatf("t%0d_sdbp", tbl[i].c), tbl[i].sdbp, sdbp1);
      chk($sformatf("t%0d_rden", tbl[i].c), rd_en1, tbl[i].rd_en);
      chk($sformatf("t%0d_rda", tbl[i].c), rd_addr1, tbl[i].rd_addr);
      chk($sformatf("t%0d_wten", tbl[i].c), wten1, tbl[i].wten);
      chk($sformatf("t%0d_wa", tbl[i].c), wa1, tbl[i].wa);
      chk($sformatf("t%0d_wd", tbl[i].c), wd1, tbl[i].wd);
      chk($sformatf("t%0d_busy", tbl[i].c), busy1, tbl[i].busy);
      frame_done = tbl[i].fd;
      adv();
      frame_done = 1'b0;
    end
    wait_until(80);
    chk("xfer_nodrop", drop1, 0);
    chk("ovr_clean", ovr1, 0);
    wait_until(111);
    chk("re_flag", sdbp1, 1);
    wait_until(116);
    chk("re_wr0", {wten1, wa1, wd1}, {1'b1, 10'd0, 16'h100});
    wait_until(119);
    chk("re_wr3", {wten1, wa1, wd1}, {1'b1, 10'd3, 16'h103});
    rst = 1'b1;
    adv();
    chk("mrst_ctl", {wten1, busy1, sdbp1, rd_en1, cfg1}, 0);
    chk("mrst_bus", {wa1, wd1, drop1}, 0);
    do_reset();
    wait_until(9);
    chk("mrst_cfg9", cfg1, 0);
    adv();
    chk("mrst_cfg10", cfg1, 1);

    // Run 3: three frames before the first tick.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_until(20 + 5 * k);
      frame_done = 1'b1;
      adv();
      frame_done = 1'b0;
    end
    wait_until(40);
    chk("drop_two", drop1, 2);
    wait_until(61);
    chk("drop_upl", sdbp1, 1);
    wait_until(100);
    chk("drop_hold", drop1, 2);
    wait_until(111);
    chk("no_pend", {sdbp1, busy1}, 0);

    // Run 4: 300 back-to-back frames saturate the drop counter.
    do_reset();
    wait_until(11);
    frame_done = 1'b1;
    repeat (300) adv();
    frame_done = 1'b0;
    wait_until(330);
    chk("drop_sat", drop1, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
